// File: rtl/sat_addsub_arbiter.sv
// Round-robin arbiter sharing one 16-bit saturating add/sub datapath between NREQ requesters.
// Optional saturation event counter enabled by defining SATARB_SAT_CNT_EN.
module sat_addsub_arbiter #(
   parameter int unsigned NREQ = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [16*NREQ-1:0]   req_a,
   input  logic [16*NREQ-1:0]   req_b,
   input  logic [NREQ-1:0]      req_sub,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [1:0]           rsp_id,
   output logic [15:0]          rsp_sum,
   output logic                 rsp_pos_ovfl,
   output logic                 rsp_neg_ovfl,
   output logic                 rsp_zero
`ifdef SATARB_SAT_CNT_EN
   ,
   output logic [15:0]          sat_cnt
`endif
);

   localparam int unsigned DW  = 16;
   localparam int unsigned IDW = 2;

   logic [IDW-1:0] ptr;
   logic [IDW-1:0] gnt_idx;
   logic           found;
   logic [2:0]     cand;
   logic [3:0]     vld4;
   logic [3:0]     sub4;
   logic [3:0]     rdy4;
   logic           can_accept;
   logic           xfer;

   logic [DW-1:0]  op_a;
   logic [DW-1:0]  op_b;
   logic           op_sub;
   logic [DW-1:0]  b_eff;
   logic [DW-1:0]  raw_sum;
   logic           pos_ovfl;
   logic           neg_ovfl;
   logic [DW-1:0]  sat_sum;

   assign vld4       = 4'(req_valid);
   assign sub4       = 4'(req_sub);
   assign can_accept = ~rsp_valid | rsp_ready;

   // Rotating priority search starting at the RR pointer
   always_comb begin
      rdy4    = '0;
      gnt_idx = '0;
      found   = 1'b0;
      cand    = '0;
      if (!rst && can_accept) begin
         for (int k = 0; k < int'(NREQ); k++) begin
            cand = 3'(ptr) + 3'(k);
            if (cand >= 3'(NREQ))
               cand = cand - 3'(NREQ);
            if (!found && vld4[cand[1:0]]) begin
               found   = 1'b1;
               gnt_idx = cand[1:0];
            end
         end
      end
      if (found)
         rdy4[gnt_idx] = 1'b1;
   end

   assign req_ready = rdy4[NREQ-1:0];
   assign xfer      = found;

   // Shared datapath: overflow is judged on the effective (possibly inverted) B operand
   always_comb begin
      op_a     = req_a[DW*gnt_idx +: DW];
      op_b     = req_b[DW*gnt_idx +: DW];
      op_sub   = sub4[gnt_idx];
      b_eff    = op_sub ? ~op_b : op_b;
      raw_sum  = op_a + b_eff + DW'(op_sub);
      pos_ovfl = ~op_a[DW-1] & ~b_eff[DW-1] &  raw_sum[DW-1];
      neg_ovfl =  op_a[DW-1] &  b_eff[DW-1] & ~raw_sum[DW-1];
      if (pos_ovfl)
         sat_sum = 16'h7FFF;
      else if (neg_ovfl)
         sat_sum = 16'h8000;
      else
         sat_sum = raw_sum;
   end

   // Single-entry output buffer and RR pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr          <= '0;
         rsp_valid    <= 1'b0;
         rsp_id       <= '0;
         rsp_sum      <= '0;
         rsp_pos_ovfl <= 1'b0;
         rsp_neg_ovfl <= 1'b0;
         rsp_zero     <= 1'b0;
      end else if (xfer) begin
         ptr          <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 2'd1;
         rsp_valid    <= 1'b1;
         rsp_id       <= gnt_idx;
         rsp_sum      <= sat_sum;
         rsp_pos_ovfl <= pos_ovfl;
         rsp_neg_ovfl <= neg_ovfl;
         rsp_zero     <= (sat_sum == '0);
      end else if (rsp_ready) begin
         rsp_valid    <= 1'b0;
      end
   end

`ifdef SATARB_SAT_CNT_EN
   // Sticky saturation event counter
   always_ff @(posedge clk) begin
      if (rst)
         sat_cnt <= '0;
      else if (xfer && (pos_ovfl || neg_ovfl) && (sat_cnt != 16'hFFFF))
         sat_cnt <= sat_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_sat_addsub_arbiter.sv
// Self-checking bench for sat_addsub_arbiter: integer-arithmetic model plus directed literal checks.
// Define SATARB_SAT_CNT_EN to also exercise the saturation counter.
module tb_sat_addsub_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [63:0] req_a;
   logic [63:0] req_b;
   logic [3:0]  req_sub;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_id;
   logic [15:0] rsp_sum;
   logic        rsp_pos_ovfl;
   logic        rsp_neg_ovfl;
   logic        rsp_zero;
`ifdef SATARB_SAT_CNT_EN
   logic [15:0] sat_cnt;
`endif

   int ncmp  = 0;
   int nfail = 0;

   sat_addsub_arbiter #(.NREQ(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_a        (req_a),
      .req_b        (req_b),
      .req_sub      (req_sub),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_id       (rsp_id),
      .rsp_sum      (rsp_sum),
      .rsp_pos_ovfl (rsp_pos_ovfl),
      .rsp_neg_ovfl (rsp_neg_ovfl),
      .rsp_zero     (rsp_zero)
`ifdef SATARB_SAT_CNT_EN
      ,
      .sat_cnt      (sat_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
      ncmp++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endfunction

   // ---------------- behavioural model ----------------
   bit          m_on = 1'b0;
   int          m_ptr;
   bit          m_valid;
   int          m_id;
   logic [15:0] m_sum;
   bit          m_pos, m_neg, m_zero;
   int          m_cnt;

   function automatic int find_grant(logic [3:0] v, int p);
      for (int k = 0; k < 4; k++)
         if (v[(p + k) % 4]) return (p + k) % 4;
      return -1;
   endfunction

   function automatic logic [3:0] exp_ready();
      int g;
      if (rst || (m_valid && !rsp_ready)) return 4'b0;
      g = find_grant(req_valid, m_ptr);
      if (g < 0) return 4'b0;
      return 4'(1 << g);
   endfunction

   always @(posedge clk) begin
      int g, sa, sb, r;
      if (rst) begin
         m_on = 1'b1; m_ptr = 0; m_valid = 1'b0; m_id = 0; m_sum = '0;
         m_pos = 1'b0; m_neg = 1'b0; m_zero = 1'b0; m_cnt = 0;
      end else if (m_on) begin
         g = (m_valid && !rsp_ready) ? -1 : find_grant(req_valid, m_ptr);
         if (g >= 0) begin
            sa = int'($signed(req_a[16*g +: 16]));
            sb = int'($signed(req_b[16*g +: 16]));
            r  = req_sub[g] ? sa - sb : sa + sb;
            m_pos = (r > 32767);
            m_neg = (r < -32768);
            if (m_pos) r = 32767;
            if (m_neg) r = -32768;
            m_sum   = 16'(r);
            m_zero  = (m_sum == 16'h0);
            m_id    = g;
            m_valid = 1'b1;
            m_ptr   = (g + 1) % 4;
            if ((m_pos || m_neg) && m_cnt < 65535) m_cnt++;
         end else if (rsp_ready) begin
            m_valid = 1'b0;
         end
      end
   end

   // Cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      if (m_on) begin
         chk("req_ready", 32'(req_ready), 32'(exp_ready()));
         chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
         chk("rsp_id",    32'(rsp_id),    32'(m_id));
         chk("rsp_sum",   32'(rsp_sum),   32'(m_sum));
         chk("rsp_flags", 32'({rsp_pos_ovfl, rsp_neg_ovfl, rsp_zero}),
                          32'({m_pos, m_neg, m_zero}));
`ifdef SATARB_SAT_CNT_EN
         chk("sat_cnt",   32'(sat_cnt),   32'(m_cnt));
`endif
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(int i, logic [15:0] a, logic [15:0] b, logic s);
      req_a[16*i +: 16] = a;
      req_b[16*i +: 16] = b;
      req_sub[i]        = s;
      req_valid[i]      = 1'b1;
   endtask

   task automatic one_op(int i, logic [15:0] a, logic [15:0] b, logic s);
      set_req(i, a, b, s);
      tick();
      req_valid = '0;
   endtask

   initial begin
      logic [15:0] exp_sum;
      rst = 1'b1; rsp_ready = 1'b0;
      req_valid = '0; req_a = '0; req_b = '0; req_sub = '0;
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("idle_valid", 32'(rsp_valid), 32'h0);
      chk("idle_ready", 32'(req_ready), 32'h0);
      chk("idle_sum",   32'(rsp_sum),   32'h0);

      rsp_ready = 1'b1;
      one_op(0, 16'h7000, 16'h2000, 1'b0);
      chk("add_pos_sum", 32'(rsp_sum), 32'h7FFF);
      chk("add_pos_flg", 32'({rsp_pos_ovfl, rsp_neg_ovfl}), 32'h2);
      chk("add_pos_id",  32'(rsp_id), 32'h0);
      one_op(1, 16'h8000, 16'hFFFF, 1'b0);
      chk("add_neg_sum", 32'(rsp_sum), 32'h8000);
      chk("add_neg_flg", 32'({rsp_pos_ovfl, rsp_neg_ovfl}), 32'h1);
      chk("add_neg_id",  32'(rsp_id), 32'h1);
      one_op(2, 16'h8000, 16'h0001, 1'b1);
      chk("sub_neg_sum", 32'(rsp_sum), 32'h8000);
      chk("sub_neg_flg", 32'({rsp_pos_ovfl, rsp_neg_ovfl}), 32'h1);
      one_op(2, 16'h7FFF, 16'hFFFF, 1'b1);
      chk("sub_pos_sum", 32'(rsp_sum), 32'h7FFF);
      chk("sub_pos_flg", 32'({rsp_pos_ovfl, rsp_neg_ovfl}), 32'h2);
      one_op(2, 16'h0005, 16'h0005, 1'b1);
      chk("sub_zero", 32'({rsp_sum, rsp_pos_ovfl, rsp_neg_ovfl, rsp_zero}), 32'h1);
      tick();
      chk("drain_valid", 32'({rsp_valid, rsp_zero}), 32'h1);

      // Reset while a result is buffered
      one_op(3, 16'h0001, 16'h0002, 1'b0);
      chk("pre_rst_valid", 32'(rsp_valid), 32'h1);
      set_req(0, 16'h0001, 16'h0001, 1'b0);
      rst = 1'b1;
      #1;
      chk("rst_ready", 32'(req_ready), 32'h0);
      tick();
      chk("rst_valid", 32'(rsp_valid), 32'h0);
      rst = 1'b0;
      req_valid = '0;

      // All four requesters continuously valid from pointer 0
      for (int i = 0; i < 4; i++)
         set_req(i, 16'(i * 256), 16'h0001, 1'b0);
      for (int n = 0; n < 5; n++) begin
         tick();
         chk("rr_id",  32'(rsp_id),  32'(n % 4));
         exp_sum = 16'((n % 4) * 256 + 1);
         chk("rr_sum", 32'(rsp_sum), 32'(exp_sum));
      end

      // Back-pressure: buffer holds id0 result while req1 waits
      req_valid = '0;
      rsp_ready = 1'b0;
      set_req(1, 16'h1234, 16'h0011, 1'b0);
      for (int n = 0; n < 3; n++) begin
         tick();
         chk("hold_ready", 32'(req_ready), 32'h0);
         chk("hold_rsp",   32'({rsp_valid, rsp_id, rsp_sum}), 32'({1'b1, 2'd0, 16'h0001}));
      end
      rsp_ready = 1'b1;
      #1;
      chk("refill_ready", 32'(req_ready), 32'h2);
      tick();
      req_valid = '0;
      chk("refill_rsp", 32'({rsp_valid, rsp_id, rsp_sum}), 32'({1'b1, 2'd1, 16'h1245}));
      tick();

`ifdef SATARB_SAT_CNT_EN
      rst = 1'b1;
      tick();
      rst = 1'b0;
      one_op(0, 16'h7000, 16'h2000, 1'b0);
      one_op(0, 16'h8000, 16'hFFFF, 1'b0);
      one_op(0, 16'h0001, 16'h0001, 1'b0);
      one_op(0, 16'h8000, 16'h0001, 1'b1);
      one_op(0, 16'h0005, 16'h0005, 1'b1);
      chk("sat_cnt_3", 32'(sat_cnt), 32'h3);
      set_req(0, 16'h7000, 16'h2000, 1'b0);
      repeat (65532) tick();
      chk("sat_cnt_max", 32'(sat_cnt), 32'hFFFF);
      repeat (3) tick();
      req_valid = '0;
      chk("sat_cnt_stick", 32'(sat_cnt), 32'hFFFF);
      tick();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule

// File: doc/sat_addsub_arbiter.md
Name: sat_addsub_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 16-bit saturating add/subtract datapath between up to four requesters (e.g. ALU issue, address-gen, PADDSB lane logic, debug).
- Each requester presents operands and an op bit under a valid/ready handshake.
- One request is granted per cycle. The saturated result and flags are registered into a single-entry output buffer, tagged with the requester ID, and handed off with valid/ready.

Parameters:
NREQ, 4, number of requesters; legal values 2..4.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous active-high reset.
req_valid  input  NREQ  per-requester request valid.
req_ready  output  NREQ  per-requester grant/accept; at most one bit high.
req_a  input  16*NREQ  operand A, requester i at [16*i+15:16*i].
req_b  input  16*NREQ  operand B, same packing.
req_sub  input  NREQ  1 = A-B, 0 = A+B.
rsp_valid  output  1  output buffer holds a result.
rsp_ready  input  1  consumer accepts result this cycle.
rsp_id  output  2  index of the requester that produced the result.
rsp_sum  output  16  saturated result.
rsp_pos_ovfl  output  1  result clamped to 0x7FFF.
rsp_neg_ovfl  output  1  result clamped to 0x8000.
rsp_zero  output  1  rsp_sum == 0x0000 (after saturation).

Behaviour:
- Reset (rst=1 at edge): rsp_valid=0, rsp_id=0, rsp_sum=0, all flags=0, RR pointer=0.
  - Reset mid-operation discards any buffered result; no partial handshakes survive.
  - req_ready is 0 while rst is high.
- Accept condition: can_accept = ~rsp_valid | rsp_ready.
  - A same-cycle drain and refill is allowed, giving full throughput of 1 op/cycle.
- Grant (combinational):
  - If can_accept, search req_valid starting at the RR pointer, ascending with wrap at NREQ-1 -> 0.
  - The first set bit i gets req_ready[i]=1; all other req_ready bits are 0.
  - If no valid requester, or !can_accept, all req_ready = 0.
- Transfer: it occurs on an edge where req_valid[i] & req_ready[i].
  - Operands of the granted requester drive the shared datapath.
  - Result, flags and id=i are loaded into the output buffer; rsp_valid=1.
  - RR pointer <= (i+1) mod NREQ.
- Latency: exactly 1 cycle from transfer edge to rsp_valid visible.
- Pointer hold: the RR pointer does not change on cycles with no transfer.
- Hold: if rsp_valid & ~rsp_ready, all rsp_* hold stable; no grant is issued.
- Drain without refill: rsp_ready with no transfer clears rsp_valid next edge; rsp_sum and flags hold their last values.
- Requester rules: requesters hold operands and req_sub stable while req_valid is high and ungranted. A requester may drop valid without penalty.
- Arithmetic (two's complement, 16-bit):
  - Effective B' = req_sub ? ~B : B, with carry-in = req_sub.
  - Raw sum S = A + B' + cin.
  - pos_ovfl = ~A[15] & ~B'[15] & S[15].
  - neg_ovfl = A[15] & B'[15] & ~S[15].
  - Overflow detection uses B', not raw B; subtract overflow must be detected correctly.
  - rsp_sum = pos_ovfl ? 0x7FFF : neg_ovfl ? 0x8000 : S.
  - pos_ovfl and neg_ovfl are never both set.
- Fairness: any continuously-valid requester is granted within NREQ accepting cycles.
- Single-requester case: with only one requester valid, it is granted every accepting cycle.

Optional Feature:
SATARB_SAT_CNT_EN
- Defined: adds output port sat_cnt [15:0].
  - Increments on every transfer whose result saturated (pos_ovfl|neg_ovfl).
  - Sticks at 0xFFFF and does not wrap.
  - Cleared to 0 by rst.
  - Update is in the same edge as the output buffer load.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then idle -> rsp_valid=0, req_ready=0, all rsp_* = 0. Assert rst for 1 cycle while rsp_valid=1 -> rsp_valid=0 next edge.
- Req0 A=0x7000, B=0x2000, add, rsp_ready=1 -> next cycle rsp_sum=0x7FFF, pos_ovfl=1, id=0. Req1 A=0x8000, B=0xFFFF, add -> 0x8000, neg_ovfl=1, id=1.
- Req2 A=0x8000, B=0x0001, sub -> 0x8000, neg_ovfl=1. A=0x7FFF, B=0xFFFF, sub -> 0x7FFF, pos_ovfl=1. A=0x0005, B=0x0005, sub -> 0x0000, zero=1, no ovfl.
- All four requesters valid continuously, rsp_ready=1, pointer=0 -> grants in order 0,1,2,3,0; one result per cycle.
- rsp_valid=1, rsp_ready=0 for 3 cycles while req1 is valid -> req_ready=0 and rsp_* stable throughout. rsp_ready=1 -> same-edge drain and refill with req1's result.
- With SATARB_SAT_CNT_EN: 3 saturating + 2 non-saturating ops -> sat_cnt=3. Force counter to 0xFFFF and do one more saturating op -> sat_cnt stays 0xFFFF.
